// File: rtl/keypad_scan_pkg.sv
// Shared types and defaults for the keypad scanner: FSM states, key code width,
// row reset pattern, default timing constants and the column priority encoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam int         KEY_CODE_W = 4;
  localparam logic [3:0] ROW_RESET  = 4'b1110;

  localparam int TICK_DIV_DEF       = 4000;
  localparam int DEBOUNCE_TICKS_DEF = 8;
  localparam int REPEAT_DELAY_DEF   = 64;
  localparam int REPEAT_RATE_DEF    = 16;

  // Lowest-index column pulled low; column 0 has the highest priority.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running divider: tick is high for one clock every TICK_DIV+1 clocks.
// Shared with the display multiplexer, so it carries no keypad knowledge.
module scan_tick_gen #(
  parameter int TICK_DIV = 4000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: strobes rows active-low, debounces press and release, pulses key_valid
// one clock after the accepting tick. Defining KEYPAD_AUTOREPEAT_EN adds repeat strobes while held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE    = REPEAT_RATE_DEF
) (
  input  logic                  clk_original,
  input  logic                  rst_n,
  input  logic [3:0]            col_in,
  output logic [3:0]            row_out,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  state_t        state, state_nxt;
  logic [3:0]    col_m, col_s;
  logic [1:0]    row_idx, col_idx;
  logic [DW-1:0] deb_cnt, rel_cnt, deb_nxt, rel_nxt;
  logic          tick, key_col;
  logic          capture, advance, deb_inc, accept;
  logic          rel_inc, rel_clr, release_done, rep_fire;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk_original),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Level of the captured key's column; the row is frozen, so this tracks that one key.
  assign key_col = col_s[col_idx];
  assign deb_nxt = deb_cnt + 1'b1;
  assign rel_nxt = rel_cnt + 1'b1;

  always_ff @(posedge clk_original) begin
    if (!rst_n) state <= SCAN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    capture      = 1'b0;
    advance      = 1'b0;
    deb_inc      = 1'b0;
    accept       = 1'b0;
    rel_inc      = 1'b0;
    rel_clr      = 1'b0;
    release_done = 1'b0;
    case (state)
      SCAN: if (tick) begin
        if (col_s != 4'b1111) begin
          capture   = 1'b1;
          state_nxt = DEBOUNCE;
        end else begin
          advance = 1'b1;
        end
      end
      DEBOUNCE: if (tick) begin
        if (!key_col) begin
          if (deb_nxt == DW'(DEBOUNCE_TICKS - 1)) begin
            accept    = 1'b1;
            state_nxt = HELD;
          end else begin
            deb_inc = 1'b1;
          end
        end else begin
          advance   = 1'b1;
          state_nxt = SCAN;
        end
      end
      HELD: if (tick) begin
        if (key_col) begin
          if (rel_nxt == DW'(DEBOUNCE_TICKS)) begin
            release_done = 1'b1;
            advance      = 1'b1;
            state_nxt    = SCAN;
          end else begin
            rel_inc = 1'b1;
          end
        end else begin
          rel_clr = 1'b1;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk_original) begin
    if (!rst_n) begin
      col_m     <= 4'b1111;
      col_s     <= 4'b1111;
      row_out   <= ROW_RESET;
      row_idx   <= '0;
      col_idx   <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      col_m     <= col_in;
      col_s     <= col_m;
      key_valid <= accept | rep_fire;
      if (advance) begin
        row_out <= {row_out[2:0], row_out[3]};
        row_idx <= row_idx + 1'b1;
      end
      if (capture) begin
        col_idx <= lowest_low_col(col_s);
        deb_cnt <= '0;
      end else if (deb_inc) begin
        deb_cnt <= deb_nxt;
      end
      if (accept) begin
        key_code <= {row_idx, col_idx};
        key_held <= 1'b1;
        rel_cnt  <= '0;
      end else if (release_done) begin
        key_held <= 1'b0;
        rel_cnt  <= '0;
      end else if (rel_inc) begin
        rel_cnt <= rel_nxt;
      end else if (rel_clr) begin
        rel_cnt <= '0;
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt, rep_nxt;
  logic          rep_first;

  assign rep_nxt  = rep_cnt + 1'b1;
  assign rep_fire = (state == HELD) && tick && !key_col &&
                    (rep_nxt == (rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE)));

  // Counts ticks since the last strobe; any released sample restarts the interval.
  always_ff @(posedge clk_original) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (accept) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (state == HELD && tick) begin
      if (key_col) begin
        rep_cnt <= '0;
      end else if (rep_fire) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_nxt;
      end
    end
  end
`else
  assign rep_fire = 1'b0;

  // Repeat timing only matters with auto-repeat built in.
  if (REPEAT_DELAY < 0 || REPEAT_RATE < 0) begin : g_repeat_cfg_unused
  end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized bench for keypad_scan: a keypad matrix model drives col_in from row_out,
// and a tick-level behavioural scanner model predicts every output on every clock.
module tb_keypad_scan;
  localparam int TD = 3;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RR = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int dut_str = 0;

  // behavioural scanner state
  int         m_row, m_cand, m_run, m_rel, m_since, m_nrep, m_nstrobe;
  bit         m_held, m_strobe;
  logic [3:0] m_code;

  keypad_scan #(
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk_original (clk),
    .rst_n        (rst_n),
    .col_in       (col_in),
    .row_out      (row_out),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_held     (key_held)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] keypad_cols(input logic [3:0] rows, input logic [15:0] keys);
    logic [3:0] c;
    c = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!rows[r])
        for (int k = 0; k < 4; k++)
          if (keys[r*4 + k]) c[k] = 1'b0;
    return c;
  endfunction

  assign col_in = keypad_cols(row_out, pressed);

  function automatic logic [3:0] row_pat(input int r);
    logic [3:0] p;
    p = 4'b1111;
    p[r] = 1'b0;
    return p;
  endfunction

  function automatic int first_low(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (!s[i]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    m_row = 0; m_cand = -1; m_run = 0; m_rel = 0;
    m_since = 0; m_nrep = 0; m_held = 0; m_code = 4'd0; m_strobe = 0;
  endtask

  // One scan tick: s is what the keypad shows on the row the model believes is driven.
  task automatic model_tick();
    logic [3:0] s;
    s = keypad_cols(row_pat(m_row), pressed);
    if (m_held) begin
      if (s[m_code[1:0]]) begin
        m_rel++;
        m_since = 0;
        if (m_rel == DB) begin
          m_held = 0; m_rel = 0; m_cand = -1;
          m_row = (m_row + 1) % 4;
        end
      end else begin
        m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
        m_since++;
        if (m_since == ((m_nrep == 0) ? RD : RR)) begin
          m_strobe = 1; m_since = 0; m_nrep++;
        end
`endif
      end
    end else if (m_cand < 0) begin
      if (s != 4'b1111) begin
        m_cand = m_row*4 + first_low(s);
        m_run  = 1;
      end else begin
        m_row = (m_row + 1) % 4;
      end
    end else if (!s[m_cand % 4]) begin
      m_run++;
      if (m_run == DB) begin
        m_held = 1; m_code = 4'(m_cand); m_strobe = 1;
        m_since = 0; m_nrep = 0; m_rel = 0;
      end
    end else begin
      m_cand = -1;
      m_row = (m_row + 1) % 4;
    end
    if (m_strobe) m_nstrobe++;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    m_strobe = 0;
    if (cyc % (TD + 1) == 0) model_tick();
    @(negedge clk);
    if (key_valid) dut_str++;
    check("key_valid", key_valid, m_strobe);
    check("row_out", row_out, row_pat(m_row));
    check("key_code", key_code, m_code);
    check("key_held", key_held, m_held);
  endtask

  task automatic run_ticks(input int n);
    repeat (n * (TD + 1)) step();
  endtask

  task automatic do_reset(input int clocks);
    rst_n = 1'b0;
    repeat (clocks) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_row_out", row_out, 4'b1110);
      check("rst_key_code", key_code, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_held", key_held, 0);
    end
    rst_n = 1'b1;
    cyc = 0;
    model_reset();
  endtask

  initial begin
    int s0, m0, a, k;
    rst_n = 1'b0;
    pressed = '0;
    m_nstrobe = 0;
    model_reset();

    do_reset(3);
    run_ticks(8);

    // single press on key 9 (row 2, column 1), then release
    pressed = 16'd1 << 9;
    s0 = dut_str;
    run_ticks(30);
    check("press9_code", key_code, 4'd9);
    check("press9_held", key_held, 1);
    check("press9_row", row_out, 4'b1011);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("press9_strobes", dut_str - s0, 1);
`endif
    pressed = '0;
    run_ticks(3);
    check("release_3_ticks_held", key_held, 1);
    run_ticks(1);
    check("release_4_ticks_held", key_held, 0);
    check("release_row_adv", row_out, 4'b0111);

    // bounce on key 0: two low ticks then high
    for (int i = 0; i < 4; i++) if (m_row != 0) run_ticks(1);
    s0 = dut_str;
    pressed = 16'd1;
    run_ticks(2);
    pressed = '0;
    run_ticks(1);
    check("bounce_row", row_out, 4'b1101);
    run_ticks(1);
    check("bounce_strobes", dut_str - s0, 0);

    // two keys on row 0 (columns 1 and 3); column 3 toggling while held
    pressed = 16'b1010;
    run_ticks(20);
    check("two_keys_code", key_code, 4'd1);
    s0 = dut_str;
    m0 = m_nstrobe;
    pressed[3] = 1'b0;
    run_ticks(3);
    pressed[3] = 1'b1;
    run_ticks(3);
    check("two_keys_held", key_held, 1);
    check("two_keys_strobes", dut_str - s0, m_nstrobe - m0);
    pressed = '0;
    run_ticks(10);

    // long hold on key 14
    s0 = dut_str;
    m0 = m_nstrobe;
    pressed = 16'd1 << 14;
    run_ticks(100);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("hold100_strobes", dut_str - s0, 1);
`else
    check("hold100_strobes", dut_str - s0, m_nstrobe - m0);
`endif

    // reset while held, key stays down and must be found again
    do_reset(1);
    run_ticks(20);
    check("rehold_code", key_code, 4'd14);
    check("rehold_held", key_held, 1);
    pressed = '0;
    run_ticks(10);

    // random key activity with occasional resets
    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 15);
      if (a == 0) begin
        pressed = '0;
      end else if (a < 4) begin
        k = $urandom_range(0, 15);
        pressed[k] = ~pressed[k];
      end else if (a == 4 && $urandom_range(0, 19) == 0) begin
        do_reset(1);
      end
      run_ticks(1);
    end
    check("total_strobes", dut_str, m_nstrobe);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
